// File: rtl/seq_div.sv
// Iterative restoring divider producing one quotient bit per clock, signed or unsigned
// per operation, with a start/busy/done handshake and Z/N/C/V flags for the ALU.
module seq_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             sign_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] residue_o,
    output logic             Z_o,
    output logic             N_o,
    output logic             C_o,
    output logic             V_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] residue_q;
    logic             qNeg_q;
    logic             rNeg_q;
    logic             ovf_q;
    logic             sign_q;
    logic             busy_q;
    logic             done_q;
    logic             z_q;
    logic             n_q;
    logic             c_q;
    logic             v_q;

    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic             ovfIn;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH-1:0] qFix;
    logic [WIDTH-1:0] rFix;

    // The most-negative magnitude still fits in WIDTH unsigned bits, so no extra bit is needed.
    always_comb begin
        aMag  = (sign_i && A_i[WIDTH-1]) ? -A_i : A_i;
        bMag  = (sign_i && B_i[WIDTH-1]) ? -B_i : B_i;
        ovfIn = sign_i && (A_i == MostNeg) && (B_i == '1);
    end

    // A borrow out of the trial subtraction means the divisor did not fit this step.
    always_comb begin
        shifted = {rem_q, dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dsr_q};
        if (trial[WIDTH]) begin
            rem_d = shifted[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_d = trial[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        qFix = qNeg_q ? -dvd_q : dvd_q;
        rFix = rNeg_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            quotient_q <= '0;
            residue_q  <= '0;
            qNeg_q     <= 1'b0;
            rNeg_q     <= 1'b0;
            ovf_q      <= 1'b0;
            sign_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
            c_q        <= 1'b0;
            v_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        sign_q <= sign_i;
                        dvd_q  <= aMag;
                        dsr_q  <= bMag;
                        // Divide-by-zero never enters the engine; its result is ready at once.
                        if (B_i == '0) begin
                            quotient_q <= '1;
                            residue_q  <= A_i;
                            z_q        <= 1'b0;
                            n_q        <= 1'b0;
                            c_q        <= 1'b0;
                            v_q        <= 1'b1;
                            done_q     <= 1'b1;
                        end else begin
                            qNeg_q  <= sign_i & (A_i[WIDTH-1] ^ B_i[WIDTH-1]);
                            rNeg_q  <= sign_i & A_i[WIDTH-1];
                            ovf_q   <= ovfIn;
                            rem_q   <= '0;
                            count_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q   <= rem_d;
                    dvd_q   <= dvd_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quotient_q <= qFix;
                    residue_q  <= rFix;
                    z_q        <= (qFix == '0);
                    n_q        <= sign_q & qFix[WIDTH-1];
                    c_q        <= (rFix != '0);
                    v_q        <= ovf_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quotient_q;
    assign residue_o  = residue_q;
    assign Z_o        = z_q;
    assign N_o        = n_q;
    assign C_o        = c_q;
    assign V_o        = v_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: a 32-bit and an 8-bit instance driven with directed
// and random divisions, compared against an arithmetic reference model.
module tb_seq_div;

    logic clk;

    logic        rst32, start32, sign32;
    logic [31:0] a32, b32;
    logic        busy32, done32, z32, n32, c32, v32;
    logic [31:0] q32, r32;

    logic        rst8, start8, sign8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, z8, n8, c8, v8;
    logic [7:0]  q8, r8;

    int checks = 0;
    int errors = 0;

    seq_div #(.WIDTH(32)) dut32 (
        .clk_i(clk), .reset_i(rst32), .start_i(start32), .A_i(a32), .B_i(b32), .sign_i(sign32),
        .busy_o(busy32), .done_o(done32), .quotient_o(q32), .residue_o(r32),
        .Z_o(z32), .N_o(n32), .C_o(c32), .V_o(v32)
    );

    seq_div #(.WIDTH(8)) dut8 (
        .clk_i(clk), .reset_i(rst8), .start_i(start8), .A_i(a8), .B_i(b8), .sign_i(sign8),
        .busy_o(busy8), .done_o(done8), .quotient_o(q8), .residue_o(r8),
        .Z_o(z8), .N_o(n8), .C_o(c8), .V_o(v8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating division on plain 64-bit integers; flags packed as {Z,N,C,V}.
    function automatic void refDiv(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input bit sgn, output logic [63:0] q, output logic [63:0] r,
                                   output logic [3:0] zncv);
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bm;
        longint sa, sb, minv;
        bit v;
        mask = (64'd1 << w) - 64'd1;
        am = a & mask;
        bm = b & mask;
        v = 1'b0;
        if (bm == 64'd0) begin
            q = mask;
            r = am;
            zncv = 4'b0001;
            return;
        end
        if (sgn) begin
            sa = $signed(am << (64 - w)) >>> (64 - w);
            sb = $signed(bm << (64 - w)) >>> (64 - w);
            minv = -(longint'(1) << (w - 1));
            v = (sa == minv) && (sb == -1);
            q = 64'(sa / sb) & mask;
            r = 64'(sa % sb) & mask;
        end else begin
            q = am / bm;
            r = am % bm;
        end
        zncv = {q == 64'd0, sgn & q[w-1], r != 64'd0, v};
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] mask;
        int k;
        mask = (64'd1 << w) - 64'd1;
        k = int'($urandom_range(0, 7));
        case (k)
            0: pick = 64'd0;
            1: pick = 64'd1;
            2: pick = 64'd1 << (w - 1);
            3: pick = mask;
            default: pick = {$urandom, $urandom} & mask;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or after a timeout).
    task automatic run32(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                         output int lat, output bit busyOk);
        a32 = a; b32 = b; sign32 = sgn; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0; a32 = $urandom; b32 = $urandom; sign32 = 1'($urandom);
        lat = 0;
        busyOk = 1'b1;
        while (!done32 && lat < 200) begin
            if (busy32 !== 1'b1) busyOk = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy32 !== 1'b0) busyOk = 1'b0;
        if (done32 !== 1'b1) lat = -1;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit sgn, input int midAt,
                        output int lat, output bit busyOk);
        a8 = a; b8 = b; sign8 = sgn; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sign8 = 1'($urandom);
        lat = 0;
        busyOk = 1'b1;
        while (!done8 && lat < 200) begin
            if (busy8 !== 1'b1) busyOk = 1'b0;
            start8 = (lat == midAt);
            @(negedge clk);
            start8 = 1'b0;
            lat++;
        end
        if (busy8 !== 1'b0) busyOk = 1'b0;
        if (done8 !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst32 = 1'b1; rst8 = 1'b1;
        repeat (2) @(negedge clk);
        rst32 = 1'b0; rst8 = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy32, done32, z32, n32, c32, v32} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset32 ctrl/flags: got %b expected 000000", {busy32, done32, z32, n32, c32, v32});
        end
        checks++;
        if (q32 !== 32'd0 || r32 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset32 results: got q=%h r=%h expected 0/0", q32, r32);
        end
        checks++;
        if ({busy8, done8, z8, n8, c8, v8} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset8 ctrl/flags: got %b expected 000000", {busy8, done8, z8, n8, c8, v8});
        end
        checks++;
        if (q8 !== 8'd0 || r8 !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset8 results: got q=%h r=%h expected 0/0", q8, r8);
        end
    endtask

    task automatic test_directed32();
        logic [31:0] ta [8] = '{32'd15, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h1234,
                                32'h80000000, 32'h80000000, 32'd100, 32'hFFFFFFFF};
        logic [31:0] tb [8] = '{32'd5, 32'd2, 32'hFFFFFFFE, 32'd0,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd0};
        bit          ts [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] eq [8] = '{32'd3, 32'hFFFFFFFD, 32'd3, 32'hFFFFFFFF,
                                32'h80000000, 32'd0, 32'd33, 32'hFFFFFFFF};
        logic [31:0] er [8] = '{32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234,
                                32'd0, 32'h80000000, 32'd1, 32'hFFFFFFFF};
        logic [3:0]  ef [8] = '{4'b0000, 4'b0110, 4'b0010, 4'b0001,
                                4'b0101, 4'b1010, 4'b0010, 4'b0001};
        int          el [8] = '{33, 33, 33, 0, 33, 33, 33, 0};
        int lat;
        bit busyOk;
        for (int i = 0; i < 8; i++) begin
            run32(ta[i], tb[i], ts[i], lat, busyOk);
            checks++;
            if (q32 !== eq[i]) begin
                errors++;
                $display("[TB] FAIL dir32[%0d] quotient: got %h expected %h", i, q32, eq[i]);
            end
            checks++;
            if (r32 !== er[i]) begin
                errors++;
                $display("[TB] FAIL dir32[%0d] residue: got %h expected %h", i, r32, er[i]);
            end
            checks++;
            if ({z32, n32, c32, v32} !== ef[i]) begin
                errors++;
                $display("[TB] FAIL dir32[%0d] ZNCV: got %b expected %b", i, {z32, n32, c32, v32}, ef[i]);
            end
            checks++;
            if (lat != el[i]) begin
                errors++;
                $display("[TB] FAIL dir32[%0d] latency: got %0d expected %0d", i, lat, el[i]);
            end
            checks++;
            if (!busyOk) begin
                errors++;
                $display("[TB] FAIL dir32[%0d] busy profile: got irregular expected high until done", i);
            end
        end
    endtask

    task automatic test_width8();
        int lat;
        bit busyOk;
        run8(8'd200, 8'd7, 1'b0, 3, lat, busyOk);
        checks++;
        if (q8 !== 8'd28 || r8 !== 8'd4 || {z8, n8, c8, v8} !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL w8 200/7 mid-start: got q=%0d r=%0d f=%b expected 28/4/0010", q8, r8, {z8, n8, c8, v8});
        end
        checks++;
        if (lat != 9 || !busyOk) begin
            errors++;
            $display("[TB] FAIL w8 200/7 timing: got lat=%0d busyOk=%0b expected 9/1", lat, busyOk);
        end
        run8(8'd9, 8'd3, 1'b0, -1, lat, busyOk);
        checks++;
        if (q8 !== 8'd3 || r8 !== 8'd0 || {z8, n8, c8, v8} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL w8 back-to-back 9/3: got q=%0d r=%0d f=%b expected 3/0/0000", q8, r8, {z8, n8, c8, v8});
        end
        checks++;
        if (lat != 9 || !busyOk) begin
            errors++;
            $display("[TB] FAIL w8 back-to-back timing: got lat=%0d busyOk=%0b expected 9/1", lat, busyOk);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (done8 !== 1'b0 || q8 !== 8'd3 || r8 !== 8'd0) begin
                errors++;
                $display("[TB] FAIL w8 hold[%0d]: got done=%b q=%0d r=%0d expected 0/3/0", i, done8, q8, r8);
            end
        end
        run8(8'h80, 8'hFF, 1'b1, -1, lat, busyOk);
        checks++;
        if (q8 !== 8'h80 || r8 !== 8'h00 || {z8, n8, c8, v8} !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL w8 overflow: got q=%h r=%h f=%b expected 80/00/0101", q8, r8, {z8, n8, c8, v8});
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        bit busyOk;
        int seenDone;
        int seenBusy;
        a32 = 32'd100; b32 = 32'd3; sign32 = 1'b0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (10) @(negedge clk);
        rst32 = 1'b1;
        @(negedge clk);
        rst32 = 1'b0;
        checks++;
        if ({busy32, done32, z32, n32, c32, v32} !== 6'b0 || q32 !== 32'd0 || r32 !== 32'd0) begin
            errors++;
            $display("[TB] FAIL abort state: got ctrl/flags=%b q=%h r=%h expected all zero",
                     {busy32, done32, z32, n32, c32, v32}, q32, r32);
        end
        seenDone = 0;
        seenBusy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done32 === 1'b1) seenDone++;
            if (busy32 === 1'b1) seenBusy++;
        end
        checks++;
        if (seenDone != 0 || seenBusy != 0) begin
            errors++;
            $display("[TB] FAIL abort quiet: got done=%0d busy=%0d cycles expected 0/0", seenDone, seenBusy);
        end
        run32(32'd100, 32'd3, 1'b0, lat, busyOk);
        checks++;
        if (q32 !== 32'd33 || r32 !== 32'd1 || {z32, n32, c32, v32} !== 4'b0010 || lat != 33) begin
            errors++;
            $display("[TB] FAIL after abort 100/3: got q=%0d r=%0d f=%b lat=%0d expected 33/1/0010/33",
                     q32, r32, {z32, n32, c32, v32}, lat);
        end
    endtask

    task automatic test_random32();
        for (int i = 0; i < 25; i++) begin
            logic [63:0] a, b, eq, er;
            logic [3:0] ef;
            bit s, busyOk;
            int lat, el;
            a = pick(32);
            b = pick(32);
            s = 1'($urandom_range(0, 1));
            refDiv(32, a, b, s, eq, er, ef);
            el = (b[31:0] == 32'd0) ? 0 : 33;
            run32(a[31:0], b[31:0], s, lat, busyOk);
            checks++;
            if (q32 !== eq[31:0] || r32 !== er[31:0] || {z32, n32, c32, v32} !== ef) begin
                errors++;
                $display("[TB] FAIL rnd32[%0d] %h/%h s=%0b: got q=%h r=%h f=%b expected q=%h r=%h f=%b",
                         i, a[31:0], b[31:0], s, q32, r32, {z32, n32, c32, v32}, eq[31:0], er[31:0], ef);
            end
            checks++;
            if (lat != el || !busyOk) begin
                errors++;
                $display("[TB] FAIL rnd32[%0d] timing: got lat=%0d busyOk=%0b expected %0d/1", i, lat, busyOk, el);
            end
        end
    endtask

    task automatic test_random8();
        for (int i = 0; i < 60; i++) begin
            logic [63:0] a, b, eq, er;
            logic [3:0] ef;
            bit s, busyOk;
            int lat, el, mid;
            a = pick(8);
            b = pick(8);
            s = 1'($urandom_range(0, 1));
            mid = int'($urandom_range(0, 12)) - 2;
            refDiv(8, a, b, s, eq, er, ef);
            el = (b[7:0] == 8'd0) ? 0 : 9;
            run8(a[7:0], b[7:0], s, mid, lat, busyOk);
            checks++;
            if (q8 !== eq[7:0] || r8 !== er[7:0] || {z8, n8, c8, v8} !== ef) begin
                errors++;
                $display("[TB] FAIL rnd8[%0d] %h/%h s=%0b: got q=%h r=%h f=%b expected q=%h r=%h f=%b",
                         i, a[7:0], b[7:0], s, q8, r8, {z8, n8, c8, v8}, eq[7:0], er[7:0], ef);
            end
            checks++;
            if (lat != el || !busyOk) begin
                errors++;
                $display("[TB] FAIL rnd8[%0d] timing: got lat=%0d busyOk=%0b expected %0d/1", i, lat, busyOk, el);
            end
        end
    endtask

    initial begin
        rst32 = 1'b1; start32 = 1'b0; a32 = '0; b32 = '0; sign32 = 1'b0;
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; sign8 = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed32();
        test_width8();
        test_reset_abort();
        test_random32();
        test_random8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
